// File: rtl/seq_pkg.sv
// Shared types and defaults for the sequence-loader state block.
package seq_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 4;

    localparam logic MODE_RELOAD = 1'b0;
    localparam logic MODE_APPEND = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_load_state.sv
// Sequence loader: pulls words from the LFSR block and writes them into sequence memory,
// either as a full reload of a programmable length or as a single appended entry per round.
module seq_load_state
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_LOAD,
    input  logic              mode_APPEND,
    input  logic [ADDR_W:0]   load_len,
    input  logic              complete_LFSR,
    input  logic [DATA_W-1:0] LFSR_output,
    output logic              en_LFSR,
    output logic [DATA_W-1:0] MEM_IN,
    output logic              MEM_LOAD,
    output logic [ADDR_W-1:0] MEM_LOAD_VAL,
    output logic [ADDR_W:0]   seq_len,
    output logic              full,
    output logic              complete_LOAD
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    seq_state_e        state_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   target_q;
    logic [ADDR_W:0]   seq_len_q;
    logic [DATA_W-1:0] data_q;
    logic              en_lfsr_q;
    logic              mem_load_q;
    logic              complete_q;

    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   idx_nxt;
    logic              full_w;

    // Zero or out-of-range lengths mean "fill the whole memory".
    always_comb begin
        eff_len = load_len;
        if (load_len == '0 || load_len > DEPTH_CNT) begin
            eff_len = DEPTH_CNT;
        end
    end

    assign idx_nxt = idx_q + ONE;
    assign full_w  = (seq_len_q == DEPTH_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            target_q   <= '0;
            seq_len_q  <= '0;
            data_q     <= '0;
            en_lfsr_q  <= 1'b0;
            mem_load_q <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_LOAD) begin
                        if (mode_APPEND == MODE_RELOAD) begin
                            seq_len_q <= '0;
                            idx_q     <= '0;
                            target_q  <= eff_len;
                            en_lfsr_q <= 1'b1;
                            state_q   <= StReq;
                        end else if (full_w) begin
                            complete_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            idx_q     <= seq_len_q;
                            target_q  <= seq_len_q + ONE;
                            en_lfsr_q <= 1'b1;
                            state_q   <= StReq;
                        end
                    end
                end
                StReq: begin
                    // Abort takes priority over a word arriving in the same cycle.
                    if (!en_LOAD) begin
                        en_lfsr_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (complete_LFSR) begin
                        data_q     <= LFSR_output;
                        en_lfsr_q  <= 1'b0;
                        mem_load_q <= 1'b1;
                        state_q    <= StWrite;
                    end
                end
                StWrite: begin
                    // The strobe already issued always lands, even if the operation is aborted.
                    mem_load_q <= 1'b0;
                    seq_len_q  <= idx_nxt;
                    idx_q      <= idx_nxt;
                    if (!en_LOAD) begin
                        state_q <= StIdle;
                    end else if (idx_nxt == target_q) begin
                        complete_q <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        en_lfsr_q <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StDone: begin
                    if (!en_LOAD) begin
                        complete_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign en_LFSR       = en_lfsr_q;
    assign MEM_IN        = data_q;
    assign MEM_LOAD      = mem_load_q;
    assign MEM_LOAD_VAL  = idx_q[ADDR_W-1:0];
    assign seq_len       = seq_len_q;
    assign full          = full_w;
    assign complete_LOAD = complete_q;

endmodule

// File: doc/seq_load_state.md
Name: seq_load_state

Overview:
- Parametrised sequence-loader state.
- Requests words from the LFSR block, captures each one and writes it into sequence memory with an index.
- Supports a programmable full-reload length and a one-entry-per-round append mode, which grows the stored sequence for successive game rounds.
- Sits between the top-level game FSM (en_/complete_ handshake) and the LFSR and sequence-memory blocks.

Parameters:
- DATA_W, 8, width of one sequence entry (LFSR word and MEM_IN).
- DEPTH, 4, maximum number of entries in sequence memory; must be ≥ 2.
- ADDR_W, $clog2(DEPTH), index width of MEM_LOAD_VAL.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_LOAD  in  1  level enable from the game FSM; deassertion aborts.
- mode_APPEND  in  1  0 = full reload, 1 = append one entry; sampled on the IDLE→REQ transition.
- load_len  in  ADDR_W+1  entries to load in reload mode; 0 or values > DEPTH are treated as DEPTH; sampled with mode_APPEND.
- complete_LFSR  in  1  one-cycle pulse: LFSR_output is valid.
- LFSR_output  in  DATA_W  new random word.
- en_LFSR  out  1  request to the LFSR block.
- MEM_IN  out  DATA_W  write data to sequence memory.
- MEM_LOAD  out  1  one-cycle write strobe.
- MEM_LOAD_VAL  out  ADDR_W  write index.
- seq_len  out  ADDR_W+1  number of valid entries currently stored.
- full  out  1  seq_len == DEPTH.
- complete_LOAD  out  1  operation finished; held while en_LOAD stays high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, seq_len 0, state IDLE.
  - Captured target count and data registers cleared.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - en_LFSR = 0, MEM_LOAD = 0.
  - On en_LOAD = 1, latch mode_APPEND and load_len.
  - Reload mode: seq_len ← 0, idx ← 0, target ← effective load_len, go to REQ.
  - Append mode with full = 1: go directly to DONE; no write, seq_len unchanged.
  - Append mode otherwise: idx ← seq_len, target ← seq_len+1, go to REQ.
- REQ:
  - en_LFSR = 1 (registered, asserted the cycle after entry).
  - On complete_LFSR = 1: capture LFSR_output into MEM_IN, go to WRITE.
  - complete_LFSR pulses arriving in any other state are ignored.
- WRITE:
  - MEM_LOAD = 1 for exactly one cycle; MEM_LOAD_VAL = idx; MEM_IN is stable for the whole cycle; en_LFSR = 0.
  - Next edge: seq_len ← idx+1, idx ← idx+1.
  - If idx+1 == target, go to DONE; otherwise go to REQ.
- Latency from complete_LFSR to MEM_LOAD: 1 cycle. Minimum spacing between strobes: 2 cycles.
- DONE:
  - complete_LOAD = 1, en_LFSR = 0.
  - Stay while en_LOAD = 1; return to IDLE when en_LOAD = 0.
- Abort: en_LOAD = 0 in REQ or WRITE → IDLE on the next edge. Exception: a WRITE already in progress completes its strobe and seq_len update. No further requests are issued; seq_len reflects the entries actually written.
- Simultaneous complete_LFSR and en_LOAD falling in REQ: abort wins; data is discarded.
- Index arithmetic never wraps: idx ≤ DEPTH-1 whenever MEM_LOAD = 1.
- full is combinational from seq_len.
- Reload mode always restarts at index 0, regardless of the previous seq_len.
- Reset mid-operation: immediate return to reset values; any MEM_LOAD in flight is deasserted.

Decomposition:
- Shared package seq_pkg: state enum (IDLE, REQ, WRITE, DONE), mode constants MODE_RELOAD/MODE_APPEND, default DATA_W/DEPTH.
- No sub-module: single FSM with index/length counters.

Test Plan:
1. Reset: rst_n low mid-REQ → all outputs 0 immediately; seq_len 0.
2. Reload, load_len = 4, LFSR words D8, C7, B6, A5 → four MEM_LOAD pulses, each 1 cycle after complete_LFSR, MEM_LOAD_VAL 0..3 with matching MEM_IN; then complete_LOAD = 1, seq_len = 4, full = 1.
3. Reload with load_len = 0 → 4 entries (DEPTH). Reload with load_len = 2 → indices 0 and 1 only; seq_len = 2.
4. Append rounds: starting from seq_len = 2, three append operations → first writes index 2, second writes index 3, third produces no MEM_LOAD and no en_LFSR, complete_LOAD = 1 the cycle after entry, seq_len stays 4.
5. Abort: reload with load_len = 4, drop en_LOAD in REQ after 2 writes → no further strobes, en_LFSR = 0 next cycle, seq_len = 2, complete_LOAD never asserts.
6. Spurious complete_LFSR in IDLE and in DONE → no MEM_LOAD; seq_len unchanged; complete_LOAD falls the cycle after en_LOAD = 0.
